// File: rtl/wb_pkg.sv
// Shared writeback types: micro-op payload layout, field widths and dst_rtype encodings.
package wb_pkg;

  localparam int ROB_IDX_W = 7;
  localparam int PDST_W    = 7;
  localparam int RTYPE_W   = 2;

  localparam logic [RTYPE_W-1:0] RT_FIX = 2'd0;
  localparam logic [RTYPE_W-1:0] RT_FLT = 2'd1;
  localparam logic [RTYPE_W-1:0] RT_X   = 2'd2;
  localparam logic [RTYPE_W-1:0] RT_PAS = 2'd3;

  typedef struct packed {
    logic [ROB_IDX_W-1:0] rob_idx;
    logic [PDST_W-1:0]    pdst;
    logic                 is_amo;
    logic                 uses_stq;
    logic [RTYPE_W-1:0]   dst_rtype;
  } wb_uop_t;

  function automatic wb_uop_t make_uop(
    input logic [ROB_IDX_W-1:0] rob_idx,
    input logic [PDST_W-1:0]    pdst,
    input logic                 is_amo,
    input logic                 uses_stq,
    input logic [RTYPE_W-1:0]   dst_rtype
  );
    wb_uop_t u;
    u.rob_idx   = rob_idx;
    u.pdst      = pdst;
    u.is_amo    = is_amo;
    u.uses_stq  = uses_stq;
    u.dst_rtype = dst_rtype;
    return u;
  endfunction

endpackage

// File: rtl/wb_starve_ctr.sv
// Counts consecutive arbitrations lost by in1 and forces an in1 grant once the limit is reached.
module wb_starve_ctr #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic in1_valid_i,
  input  logic in0_fire_i,
  input  logic in1_fire_i,
  output logic force_in1_o
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  // Saturating loss counter; cleared whenever in1 wins or stops requesting.
  always_comb begin
    cnt_d = cnt_q;
    if (in1_fire_i || !in1_valid_i) begin
      cnt_d = 4'd0;
    end else if (in0_fire_i) begin
      cnt_d = (cnt_q < LIMIT) ? (cnt_q + 4'd1) : cnt_q;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign force_in1_o = (cnt_q == LIMIT) & in1_valid_i;

endmodule

// File: rtl/wb_port_scheduler.sv
// Two-requester writeback arbiter feeding a one-entry registered output stage;
// in0 has priority, in1 is protected from starvation by wb_starve_ctr.
module wb_port_scheduler
  import wb_pkg::*;
#(
  parameter int DATA_W       = 64,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 io_flush,
  input  logic                 io_in_0_valid,
  output logic                 io_in_0_ready,
  input  logic [ROB_IDX_W-1:0] io_in_0_bits_uop_rob_idx,
  input  logic [PDST_W-1:0]    io_in_0_bits_uop_pdst,
  input  logic                 io_in_0_bits_uop_is_amo,
  input  logic                 io_in_0_bits_uop_uses_stq,
  input  logic [RTYPE_W-1:0]   io_in_0_bits_uop_dst_rtype,
  input  logic [DATA_W-1:0]    io_in_0_bits_data,
  input  logic                 io_in_1_valid,
  output logic                 io_in_1_ready,
  input  logic [ROB_IDX_W-1:0] io_in_1_bits_uop_rob_idx,
  input  logic [PDST_W-1:0]    io_in_1_bits_uop_pdst,
  input  logic                 io_in_1_bits_uop_is_amo,
  input  logic                 io_in_1_bits_uop_uses_stq,
  input  logic [RTYPE_W-1:0]   io_in_1_bits_uop_dst_rtype,
  input  logic [DATA_W-1:0]    io_in_1_bits_data,
  input  logic                 io_in_1_bits_predicated,
  output logic                 io_out_valid,
  input  logic                 io_out_ready,
  output logic [ROB_IDX_W-1:0] io_out_bits_uop_rob_idx,
  output logic [PDST_W-1:0]    io_out_bits_uop_pdst,
  output logic                 io_out_bits_uop_is_amo,
  output logic                 io_out_bits_uop_uses_stq,
  output logic [RTYPE_W-1:0]   io_out_bits_uop_dst_rtype,
  output logic [DATA_W-1:0]    io_out_bits_data,
  output logic                 io_out_bits_predicated,
  output logic                 io_out_src
);

  wb_uop_t           in0_uop_s;
  wb_uop_t           in1_uop_s;
  logic              can_accept_s;
  logic              force_in1_s;
  logic              grant0_s;
  logic              grant1_s;
  logic              fire0_s;
  logic              fire1_s;

  logic              out_valid_q, out_valid_d;
  wb_uop_t           out_uop_q,   out_uop_d;
  logic [DATA_W-1:0] out_data_q,  out_data_d;
  logic              out_pred_q,  out_pred_d;
  logic              out_src_q,   out_src_d;

  assign in0_uop_s = make_uop(io_in_0_bits_uop_rob_idx, io_in_0_bits_uop_pdst,
                              io_in_0_bits_uop_is_amo, io_in_0_bits_uop_uses_stq,
                              io_in_0_bits_uop_dst_rtype);
  assign in1_uop_s = make_uop(io_in_1_bits_uop_rob_idx, io_in_1_bits_uop_pdst,
                              io_in_1_bits_uop_is_amo, io_in_1_bits_uop_uses_stq,
                              io_in_1_bits_uop_dst_rtype);

  wb_starve_ctr #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve_ctr (
    .clock        (clock),
    .reset        (reset),
    .in1_valid_i  (io_in_1_valid),
    .in0_fire_i   (fire0_s),
    .in1_fire_i   (fire1_s),
    .force_in1_o  (force_in1_s)
  );

  // Grant is computed from valids only; readiness is layered on top of it.
  always_comb begin
    can_accept_s  = ~io_flush & (~out_valid_q | io_out_ready);
    grant0_s      = io_in_0_valid & ~force_in1_s;
    grant1_s      = io_in_1_valid & ~grant0_s;
    io_in_0_ready = ~reset & can_accept_s & grant0_s;
    io_in_1_ready = ~reset & can_accept_s & grant1_s;
    fire0_s       = io_in_0_valid & io_in_0_ready;
    fire1_s       = io_in_1_valid & io_in_1_ready;
  end

  // Output stage next state; flush wins over both a new beat and a drain.
  always_comb begin
    out_valid_d = out_valid_q;
    out_uop_d   = out_uop_q;
    out_data_d  = out_data_q;
    out_pred_d  = out_pred_q;
    out_src_d   = out_src_q;
    if (io_flush) begin
      out_valid_d = 1'b0;
    end else if (fire0_s || fire1_s) begin
      out_valid_d = 1'b1;
    end else if (io_out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
    if (fire0_s) begin
      out_uop_d  = in0_uop_s;
      out_data_d = io_in_0_bits_data;
      out_pred_d = 1'b0;
      out_src_d  = 1'b0;
    end else if (fire1_s) begin
      out_uop_d  = in1_uop_s;
      out_data_d = io_in_1_bits_data;
      out_pred_d = io_in_1_bits_predicated;
      out_src_d  = 1'b1;
    end else begin
      out_uop_d  = out_uop_q;
      out_data_d = out_data_q;
      out_pred_d = out_pred_q;
      out_src_d  = out_src_q;
    end
  end

  // Output stage registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_uop_q   <= '0;
      out_data_q  <= '0;
      out_pred_q  <= 1'b0;
      out_src_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_uop_q   <= out_uop_d;
      out_data_q  <= out_data_d;
      out_pred_q  <= out_pred_d;
      out_src_q   <= out_src_d;
    end
  end

  assign io_out_valid               = out_valid_q;
  assign io_out_bits_uop_rob_idx    = out_uop_q.rob_idx;
  assign io_out_bits_uop_pdst       = out_uop_q.pdst;
  assign io_out_bits_uop_is_amo     = out_uop_q.is_amo;
  assign io_out_bits_uop_uses_stq   = out_uop_q.uses_stq;
  assign io_out_bits_uop_dst_rtype  = out_uop_q.dst_rtype;
  assign io_out_bits_data           = out_data_q;
  assign io_out_bits_predicated     = out_pred_q;
  assign io_out_src                 = out_src_q;

endmodule

// File: tb/tb_wb_port_scheduler.sv
// Scoreboard bench for wb_port_scheduler: directed scenarios followed by random traffic.
module tb_wb_port_scheduler;
  import wb_pkg::*;

  localparam int DATA_W = 64;
  localparam int LIMIT  = 4;

  typedef struct packed {
    logic [6:0]        rob_idx;
    logic [6:0]        pdst;
    logic              is_amo;
    logic              uses_stq;
    logic [1:0]        dst_rtype;
    logic [DATA_W-1:0] data;
    logic              predicated;
    logic              src;
  } beat_t;

  logic clock = 1'b0;
  logic reset, io_flush, io_out_ready, io_out_valid, io_out_src;
  logic io_in_0_valid, io_in_0_ready, io_in_1_valid, io_in_1_ready;
  logic [6:0] io_in_0_bits_uop_rob_idx, io_in_0_bits_uop_pdst;
  logic [6:0] io_in_1_bits_uop_rob_idx, io_in_1_bits_uop_pdst;
  logic io_in_0_bits_uop_is_amo, io_in_0_bits_uop_uses_stq;
  logic io_in_1_bits_uop_is_amo, io_in_1_bits_uop_uses_stq, io_in_1_bits_predicated;
  logic [1:0] io_in_0_bits_uop_dst_rtype, io_in_1_bits_uop_dst_rtype;
  logic [DATA_W-1:0] io_in_0_bits_data, io_in_1_bits_data, io_out_bits_data;
  logic [6:0] io_out_bits_uop_rob_idx, io_out_bits_uop_pdst;
  logic io_out_bits_uop_is_amo, io_out_bits_uop_uses_stq, io_out_bits_predicated;
  logic [1:0] io_out_bits_uop_dst_rtype;

  beat_t sb[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  bit    mon_en   = 1'b0;
  int    m_losses = 0;
  int    dut_fire = -1;

  wb_port_scheduler #(.DATA_W(DATA_W), .STARVE_LIMIT(LIMIT)) dut (
    .clock(clock), .reset(reset), .io_flush(io_flush),
    .io_in_0_valid(io_in_0_valid), .io_in_0_ready(io_in_0_ready),
    .io_in_0_bits_uop_rob_idx(io_in_0_bits_uop_rob_idx), .io_in_0_bits_uop_pdst(io_in_0_bits_uop_pdst),
    .io_in_0_bits_uop_is_amo(io_in_0_bits_uop_is_amo), .io_in_0_bits_uop_uses_stq(io_in_0_bits_uop_uses_stq),
    .io_in_0_bits_uop_dst_rtype(io_in_0_bits_uop_dst_rtype), .io_in_0_bits_data(io_in_0_bits_data),
    .io_in_1_valid(io_in_1_valid), .io_in_1_ready(io_in_1_ready),
    .io_in_1_bits_uop_rob_idx(io_in_1_bits_uop_rob_idx), .io_in_1_bits_uop_pdst(io_in_1_bits_uop_pdst),
    .io_in_1_bits_uop_is_amo(io_in_1_bits_uop_is_amo), .io_in_1_bits_uop_uses_stq(io_in_1_bits_uop_uses_stq),
    .io_in_1_bits_uop_dst_rtype(io_in_1_bits_uop_dst_rtype), .io_in_1_bits_data(io_in_1_bits_data),
    .io_in_1_bits_predicated(io_in_1_bits_predicated),
    .io_out_valid(io_out_valid), .io_out_ready(io_out_ready),
    .io_out_bits_uop_rob_idx(io_out_bits_uop_rob_idx), .io_out_bits_uop_pdst(io_out_bits_uop_pdst),
    .io_out_bits_uop_is_amo(io_out_bits_uop_is_amo), .io_out_bits_uop_uses_stq(io_out_bits_uop_uses_stq),
    .io_out_bits_uop_dst_rtype(io_out_bits_uop_dst_rtype), .io_out_bits_data(io_out_bits_data),
    .io_out_bits_predicated(io_out_bits_predicated), .io_out_src(io_out_src)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] rand_rtype();
    case ($urandom_range(3))
      0:       return RT_FIX;
      1:       return RT_FLT;
      2:       return RT_X;
      default: return RT_PAS;
    endcase
  endfunction

  task automatic randomize_payload();
    io_in_0_bits_uop_rob_idx   = 7'($urandom);
    io_in_0_bits_uop_pdst      = 7'($urandom);
    io_in_0_bits_uop_is_amo    = 1'($urandom);
    io_in_0_bits_uop_uses_stq  = 1'($urandom);
    io_in_0_bits_uop_dst_rtype = rand_rtype();
    io_in_0_bits_data          = {$urandom, $urandom};
    io_in_1_bits_uop_rob_idx   = 7'($urandom);
    io_in_1_bits_uop_pdst      = 7'($urandom);
    io_in_1_bits_uop_is_amo    = 1'($urandom);
    io_in_1_bits_uop_uses_stq  = 1'($urandom);
    io_in_1_bits_uop_dst_rtype = rand_rtype();
    io_in_1_bits_data          = {$urandom, $urandom};
    io_in_1_bits_predicated    = 1'($urandom);
  endtask

  // Reference model: occupancy of the output slot is the scoreboard depth;
  // in1 wins on its own, or after losing LIMIT arbitrations in a row.
  task automatic step();
    beat_t exp_b;
    bit    room, forced, want0, want1, f0, f1;
    #1;
    room   = !reset && !io_flush && (sb.size() == 0 || io_out_ready);
    forced = io_in_1_valid && (m_losses == LIMIT);
    want0  = io_in_0_valid && !forced;
    want1  = io_in_1_valid && !want0;
    f0     = room && want0;
    f1     = room && want1;
    chk("in0_ready", 128'(io_in_0_ready), 128'(f0));
    chk("in1_ready", 128'(io_in_1_ready), 128'(f1));
    dut_fire = io_in_1_ready ? 1 : (io_in_0_ready ? 0 : -1);
    if (f1)
      exp_b = {io_in_1_bits_uop_rob_idx, io_in_1_bits_uop_pdst, io_in_1_bits_uop_is_amo,
               io_in_1_bits_uop_uses_stq, io_in_1_bits_uop_dst_rtype, io_in_1_bits_data,
               io_in_1_bits_predicated, 1'b1};
    else
      exp_b = {io_in_0_bits_uop_rob_idx, io_in_0_bits_uop_pdst, io_in_0_bits_uop_is_amo,
               io_in_0_bits_uop_uses_stq, io_in_0_bits_uop_dst_rtype, io_in_0_bits_data,
               1'b0, 1'b0};
    if (reset) m_losses = 0;
    else if (f1 || !io_in_1_valid) m_losses = 0;
    else if (f0 && m_losses < LIMIT) m_losses++;
    @(posedge clock);
    if (f0 || f1) sb.push_back(exp_b);
    #1;
  endtask

  task automatic drive(input bit v0, input bit v1, input bit ordy, input bit fl, input bit rst);
    io_in_0_valid = v0;
    io_in_1_valid = v1;
    io_out_ready  = ordy;
    io_flush      = fl;
    reset         = rst;
    step();
  endtask

  // Monitor: every cycle the presented beat must match the scoreboard head.
  always @(negedge clock) begin
    beat_t act;
    if (mon_en) begin
      act = {io_out_bits_uop_rob_idx, io_out_bits_uop_pdst, io_out_bits_uop_is_amo,
             io_out_bits_uop_uses_stq, io_out_bits_uop_dst_rtype, io_out_bits_data,
             io_out_bits_predicated, io_out_src};
      if (sb.size() == 0) begin
        chk("out_valid_idle", 128'(io_out_valid), 128'(1'b0));
      end else begin
        chk("out_valid_busy", 128'(io_out_valid), 128'(1'b1));
        chk("out_beat", 128'(act), 128'(sb[0]));
        if (reset || io_flush || io_out_ready) void'(sb.pop_front());
      end
    end
  end

  initial begin
    int exp_seq[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    int exp_rst[5]  = '{0, 0, 0, 0, 1};
    randomize_payload();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    mon_en = 1'b1;
    chk("rst_out_valid", 128'(io_out_valid), 128'(1'b0));
    chk("rst_out_src", 128'(io_out_src), 128'(1'b0));
    chk("rst_out_bits", 128'({io_out_bits_uop_rob_idx, io_out_bits_uop_pdst, io_out_bits_uop_is_amo,
        io_out_bits_uop_uses_stq, io_out_bits_uop_dst_rtype, io_out_bits_data,
        io_out_bits_predicated}), 128'(0));

    // Single in0 beat appears one cycle later.
    randomize_payload();
    io_in_0_bits_uop_rob_idx = 7'd5;
    io_in_0_bits_data        = 64'hDEAD;
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("d_in0_valid", 128'(io_out_valid), 128'(1'b1));
    chk("d_in0_rob", 128'(io_out_bits_uop_rob_idx), 128'(7'd5));
    chk("d_in0_data", 128'(io_out_bits_data), 128'(64'hDEAD));
    chk("d_in0_src_pred", 128'({io_out_src, io_out_bits_predicated}), 128'(2'b00));

    // Starvation guard: in1 forced through every fifth grant.
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      randomize_payload();
      drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("grant_seq", 128'(dut_fire), 128'(exp_seq[i]));
    end

    // in1 beat held under backpressure, then drained.
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    randomize_payload();
    io_in_1_bits_predicated = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("hold_no_ready", 128'({io_in_0_ready, io_in_1_ready, dut_fire == -1}), 128'(3'b001));
      chk("hold_pred", 128'({io_out_valid, io_out_bits_predicated, io_out_src}), 128'(3'b111));
    end
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("drain_refill", 128'(dut_fire), 128'(1));

    // Flush kills the output beat and blocks in0 for that cycle.
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    randomize_payload();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("flush_in0_blocked", 128'(dut_fire), 128'(-1));
    chk("flush_out_valid", 128'(io_out_valid), 128'(1'b0));
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("after_flush_accept", 128'(dut_fire), 128'(0));

    // Reset mid-operation with losses=3 and a beat in flight.
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("rst_readys", 128'({io_in_0_ready, io_in_1_ready}), 128'(2'b00));
    chk("rst_mid_valid", 128'(io_out_valid), 128'(1'b0));
    for (int i = 0; i < 5; i++) begin
      randomize_payload();
      drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("post_rst_grant", 128'(dut_fire), 128'(exp_rst[i]));
    end

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      randomize_payload();
      drive($urandom_range(9) < 7, $urandom_range(9) < 7, $urandom_range(9) < 6,
            $urandom_range(15) == 0, $urandom_range(199) == 0);
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
